// File: rtl/regfile_wb_pkg.sv
// Shared widths and constants for the writeback-end register file.
// Holds bus widths, register count, XZR address and the zero word.
package regfile_wb_pkg;

    localparam int DataBus    = 64;
    localparam int RegBus     = 64;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 31;

    localparam logic [RegAddrBus-1:0] XZRAddr  = 5'd31;
    localparam logic [RegBus-1:0]     ZeroWord = '0;
    localparam logic                  RstEnable = 1'b1;

    // X31 reads as zero and swallows writes.
    function automatic logic is_xzr(
        input logic [RegAddrBus-1:0] addr
    );
        return addr == XZRAddr;
    endfunction

endpackage

// File: rtl/regfile_wb_wb_sel.sv
// MemtoReg writeback mux: picks load data or ALU result.
// Ports: memtoreg_i, ld_data_i, alu_data_i in; wdata_o out.
module wb_sel
    import regfile_wb_pkg::*;
(
    input  logic               memtoreg_i,
    input  logic [DataBus-1:0] ld_data_i,
    input  logic [DataBus-1:0] alu_data_i,
    output logic [DataBus-1:0] wdata_o
);

    assign wdata_o = memtoreg_i ? ld_data_i : alu_data_i;

endmodule

// File: rtl/regfile_wb.sv
// X0-X30 register file with WB commit and two combinational read ports.
// Ports: clk, rst (sync, active-high); wb_rdata/wb_result/wb_waddr,
// wb_MemtoReg, wb_RegWrite in; re1/raddr1, re2/raddr2 in;
// rdata1, rdata2, wb_wdata out.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DataBus-1:0]    wb_rdata,
    input  logic [DataBus-1:0]    wb_result,
    input  logic [RegAddrBus-1:0] wb_waddr,
    input  logic                  wb_MemtoReg,
    input  logic                  wb_RegWrite,
    input  logic                  re1,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic                  re2,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic [RegBus-1:0]     rdata1,
    output logic [RegBus-1:0]     rdata2,
    output logic [DataBus-1:0]    wb_wdata
);

    logic [RegBus-1:0] regs_q [RegNum];
    logic              we_d;
    logic              hit1_d;
    logic              hit2_d;

    wb_sel u_wb_sel (
        .memtoreg_i (wb_MemtoReg),
        .ld_data_i  (wb_rdata),
        .alu_data_i (wb_result),
        .wdata_o    (wb_wdata)
    );

    assign we_d = wb_RegWrite && !is_xzr(wb_waddr);

    // Reset takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < RegNum; i++) begin
                regs_q[i] <= ZeroWord;
            end
        end else if (we_d) begin
            regs_q[wb_waddr] <= wb_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit1_d = wb_RegWrite && (wb_waddr == raddr1)
                    && !is_xzr(raddr1);
    assign hit2_d = wb_RegWrite && (wb_waddr == raddr2)
                    && !is_xzr(raddr2);
`else
    // In-flight write is invisible; hazard unit stalls instead.
    assign hit1_d = 1'b0;
    assign hit2_d = 1'b0;
`endif

    always_comb begin
        rdata1 = ZeroWord;
        if (rst != RstEnable && re1 && !is_xzr(raddr1)) begin
            rdata1 = hit1_d ? wb_wdata : regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = ZeroWord;
        if (rst != RstEnable && re2 && !is_xzr(raddr2)) begin
            rdata2 = hit2_d ? wb_wdata : regs_q[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb.
// Follows REGFILE_BYPASS_EN for the same-cycle hazard expectations.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic [63:0] wb_rdata;
    logic [63:0] wb_result;
    logic [4:0]  wb_waddr;
    logic        wb_MemtoReg;
    logic        wb_RegWrite;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic [63:0] wb_wdata;

    int tests;
    int fails;

    regfile_wb dut (
        .clk         (clk),
        .rst         (rst),
        .wb_rdata    (wb_rdata),
        .wb_result   (wb_result),
        .wb_waddr    (wb_waddr),
        .wb_MemtoReg (wb_MemtoReg),
        .wb_RegWrite (wb_RegWrite),
        .re1         (re1),
        .raddr1      (raddr1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .wb_wdata    (wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_RegWrite = 1'b0;
        wb_MemtoReg = 1'b0;
        wb_rdata    = '0;
        wb_result   = '0;
        wb_waddr    = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] v);
        wb_RegWrite = 1'b1;
        wb_MemtoReg = 1'b0;
        wb_waddr    = a;
        wb_result   = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd0;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        tests++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h0) begin
            fails++;
            $display("FAIL rst_out got %h/%h want 0",
                     rdata1, rdata2);
        end
        tick();
        rst = 1'b0;
        wr(5'd5, 64'hDEAD);
        raddr1 = 5'd5;
        #1;
        tests++;
        if (rdata1 !== 64'hDEAD) begin
            fails++;
            $display("FAIL preload_x5 got %h want dead", rdata1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            tests++;
            if (rdata1 !== 64'h0 || rdata2 !== 64'h0) begin
                fails++;
                $display("FAIL rst_clr x%0d got %h/%h want 0",
                         i, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_alu_write();
        wr(5'd3, 64'h8);
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        tests++;
        if (rdata1 !== 64'h8 || rdata2 !== 64'h8) begin
            fails++;
            $display("FAIL alu_x3 got %h/%h want 8", rdata1, rdata2);
        end
    endtask

    task automatic test_load_xzr();
        wb_RegWrite = 1'b1;
        wb_MemtoReg = 1'b1;
        wb_rdata    = 64'h7;
        wb_result   = 64'h55;
        wb_waddr    = 5'd31;
        raddr1      = 5'd31;
        #1;
        tests++;
        if (wb_wdata !== 64'h7) begin
            fails++;
            $display("FAIL mux_load got %h want 7", wb_wdata);
        end
        tests++;
        if (rdata1 !== 64'h0) begin
            fails++;
            $display("FAIL xzr_same got %h want 0", rdata1);
        end
        tick();
        raddr1 = 5'd31;
        raddr2 = 5'd2;
        #1;
        tests++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h0) begin
            fails++;
            $display("FAIL xzr_after got %h/%h want 0", rdata1, rdata2);
        end
        raddr2 = 5'd3;
        #1;
        tests++;
        if (rdata2 !== 64'h8) begin
            fails++;
            $display("FAIL xzr_x3 got %h want 8", rdata2);
        end
        wb_waddr = 5'd2;
        tick();
        idle();
        raddr1 = 5'd2;
        #1;
        tests++;
        if (rdata1 !== 64'h7) begin
            fails++;
            $display("FAIL load_x2 got %h want 7", rdata1);
        end
    endtask

    task automatic test_hazard();
        logic [63:0] exp;
        wr(5'd4, 64'h1);
        wb_RegWrite = 1'b1;
        wb_waddr    = 5'd4;
        wb_result   = 64'h2;
        raddr1      = 5'd4;
        raddr2      = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 64'h2;
`else
        exp = 64'h1;
`endif
        tests++;
        if (rdata1 !== exp || rdata2 !== exp) begin
            fails++;
            $display("FAIL hazard_same got %h/%h want %h",
                     rdata1, rdata2, exp);
        end
        tick();
        idle();
        #1;
        tests++;
        if (rdata1 !== 64'h2 || rdata2 !== 64'h2) begin
            fails++;
            $display("FAIL hazard_next got %h/%h want 2",
                     rdata1, rdata2);
        end
    endtask

    task automatic test_enables();
        re1    = 1'b0;
        raddr1 = 5'd3;
        re2    = 1'b1;
        raddr2 = 5'd3;
        #1;
        tests++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h8) begin
            fails++;
            $display("FAIL re1_off got %h/%h want 0/8", rdata1, rdata2);
        end
        re1 = 1'b1;
        re2 = 1'b0;
        raddr2 = 5'd2;
        #1;
        tests++;
        if (rdata2 !== 64'h0) begin
            fails++;
            $display("FAIL re2_off got %h want 0", rdata2);
        end
        re2 = 1'b1;
        wb_RegWrite = 1'b0;
        wb_waddr    = 5'd3;
        wb_result   = 64'hFF;
        #1;
        tests++;
        if (rdata1 !== 64'h8 || wb_wdata !== 64'hFF) begin
            fails++;
            $display("FAIL nowe_byp got %h wd %h want 8 wd ff",
                     rdata1, wb_wdata);
        end
        tick();
        idle();
        #1;
        tests++;
        if (rdata1 !== 64'h8) begin
            fails++;
            $display("FAIL nowe_x3 got %h want 8", rdata1);
        end
    endtask

    task automatic test_reset_collision();
        rst         = 1'b1;
        wb_RegWrite = 1'b1;
        wb_waddr    = 5'd6;
        wb_result   = 64'h9;
        tick();
        rst = 1'b0;
        idle();
        raddr1 = 5'd6;
        raddr2 = 5'd3;
        #1;
        tests++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h0) begin
            fails++;
            $display("FAIL rst_coll got %h/%h want 0", rdata1, rdata2);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        rst = 1'b1;
        re1 = 1'b0; raddr1 = '0;
        re2 = 1'b0; raddr2 = '0;
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_load_xzr();
        test_hazard();
        test_enables();
        test_reset_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Architectural register file at the writeback end of the ARMv8 five-stage pipeline. It consumes the MEM/WB pipeline register outputs (load data, ALU result, destination address, MemtoReg, RegWrite), selects the writeback value, and commits it to X0–X30. It serves two combinational read ports to the ID stage. X31 is the zero register (XZR). An optional same-cycle write-to-read bypass removes the WB→ID structural hazard.

## Interface
Parameters:
- none; widths come from `DataBus`/`RegBus` (64), `RegAddrBus` (5) in defines.v.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high (`RstEnable`).
- wb_rdata  in  64  load data from MEM/WB.
- wb_result  in  64  ALU result from MEM/WB.
- wb_waddr  in  5  destination register.
- wb_MemtoReg  in  1  1 = write wb_rdata, 0 = write wb_result.
- wb_RegWrite  in  1  write enable.
- re1  in  1  read enable, port 1 (Rn).
- raddr1  in  5  read address, port 1.
- re2  in  1  read enable, port 2 (Rm/Rt).
- raddr2  in  5  read address, port 2.
- rdata1  out  64  read data, port 1 (combinational).
- rdata2  out  64  read data, port 2 (combinational).
- wb_wdata  out  64  selected writeback value (combinational; for forwarding into EX).

## Operation
- Writeback value: wb_wdata = wb_MemtoReg ? wb_rdata : wb_result. This is purely combinational and is driven even when wb_RegWrite=0.
- Write rule: on posedge, if rst=0, wb_RegWrite=1 and wb_waddr≠31, then regs[wb_waddr] ← wb_wdata. Writes to 31 are discarded.
- Storage: 31 × 64-bit registers, indices 0–30. There is no physical register 31.
- Read rules, per port, in priority order:
  - rst=1 → `ZeroWord`.
  - reN=0 → `ZeroWord`.
  - raddrN=31 → `ZeroWord` (XZR).
  - bypass hit (see Configuration) → wb_wdata.
  - otherwise → regs[raddrN].
- Both ports may read the same address; each returns the same value.
- Reset: on a posedge with rst=1, all 31 registers clear to `ZeroWord`. A write presented in the same cycle is dropped; reset wins. Reset asserted mid-stream clears the architectural state regardless of pending MEM/WB contents.
- No stall or handshake. The file accepts one write per cycle unconditionally.

## Timing
- Write latency is one cycle. Without the bypass, data written at edge N is readable after edge N.
- Read latency is zero; rdata1/rdata2 are combinational from the address, the enable and the register state.
- Output values under reset: rdata1, rdata2 = 0. wb_wdata follows its inputs and is not reset; the MEM/WB register already zeroes those inputs.
- Simultaneous write and read of the same register, with bypass compiled in: the read returns the new value in the same cycle. Without bypass it returns the old value, and the pipeline must insert the hazard bubble.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read port hits when wb_RegWrite=1, wb_waddr=raddrN, and raddrN≠31. A hit returns wb_wdata.
- Not defined: the read path never sees the in-flight write. The ID/EX hazard unit must stall one cycle on a WB→ID dependency.

## Structure
- The following belong in defines.v alongside the existing `RstEnable`, `ZeroWord` and `RegBus` items:
  - `RegNum` (31)
  - `XZRAddr` (5'd31)
  - `RegAddrBus`
  - `DataBus`
- Sub-module `wb_sel`: the 2:1 MemtoReg writeback mux. It is instantiated once; its output is wb_wdata. Everything else lives in regfile_wb.

## Test plan
- Reset: preload X5=64'hDEAD, then rst=1 for one edge → read X5 returns 0; all 31 registers read 0.
- Write/read ALU path: RegWrite=1, MemtoReg=0, waddr=3, result=64'h8 → after the edge, raddr1=3 returns 64'h8.
- Load path and XZR:
  - MemtoReg=1, rdata=64'h7, waddr=31, RegWrite=1 → reading 31 returns 0; no register changes.
  - Repeat with waddr=2 → X2=64'h7.
- Same-cycle hazard: X4=64'h1; write X4←64'h2 while raddr1=raddr2=4.
  - With `REGFILE_BYPASS_EN`: both ports return 64'h2 in that cycle.
  - Without it: both return 64'h1 that cycle and 64'h2 the next.
- Enables and RegWrite=0: re1=0, raddr1=3 → 0. RegWrite=0, waddr=3, result=64'hFF → X3 unchanged and no bypass.
- Reset vs write collision: rst=1 together with a write of X6←64'h9 → X6 reads 0 after the edge.
